fp_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered floating-point multiplier (`mul_fp_clk`-style: enable-gated input and output registers) among NUM_REQ requesters in the FFT datapath, such as butterfly twiddle-multiply ports. It accepts at most one operand pair per cycle, drives the multiplier's operands and enable, and tracks in-flight operations with a tag pipeline. Each product is returned to the requester that issued it, with a one-hot valid.

---
 rtl/fp_mul_arbiter_if.sv | 31 +++
 rtl/fp_mul_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if: requester handshake, result return and multiplier
// operand/result signals shared between fp_mul_arbiter and its neighbours.
// The arbiter connects through the slave modport; the requesters and the
// multiplier wrapper sit on the master side.
interface fp_mul_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          arb_hold;
    logic                          mul_ena;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [DATA_WIDTH-1:0]         mul_result;
    logic [NUM_REQ-1:0]            res_valid;
    logic [DATA_WIDTH-1:0]         res_data;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, arb_hold, mul_result,
        input  req_ready, mul_ena, mul_a, mul_b, res_valid, res_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, arb_hold, mul_result,
        output req_ready, mul_ena, mul_a, mul_b, res_valid, res_data, busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one registered FP multiplier among NUM_REQ
// requesters. One operand pair is granted per cycle (round-robin by default),
// a tag pipeline MUL_LATENCY deep remembers who issued each operation, and
// the product is returned to that requester with a one-hot strobe.
// Build option: define FP_MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins, no rotating pointer).
module fp_mul_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_mul_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                  state;
    logic                    ena;

    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        cand;
    logic                    found;
    logic                    issue;
    logic                    retire;

    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [DATA_WIDTH-1:0]   op_a_p0;
    logic [DATA_WIDTH-1:0]   op_b_p0;

    logic                    vld_p [MUL_LATENCY];
    logic [PTR_W-1:0]        idx_p [MUL_LATENCY];

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        inflight_next;

    logic [NUM_REQ-1:0]      res_vld;
    logic [DATA_WIDTH-1:0]   res_dat;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest asserted index wins unless grants are held.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'(k);
            if (!found && !bus.arb_hold && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant = onehot(grant_idx);
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    int               pos;

    // Round-robin: first asserted request at or after rr_ptr, wrapping upward.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = PTR_W'(pos);
            if (!found && !bus.arb_hold && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant = onehot(grant_idx);
        end
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end
`endif

    assign issue  = |(grant & bus.req_valid);
    assign retire = vld_p[MUL_LATENCY-1];

    // Operand mux for the granted requester, built with constant slice bases.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                sel_a = bus.req_a[k*DATA_WIDTH +: DATA_WIDTH];
                sel_b = bus.req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---- issue stage: operand registers feeding the multiplier ----
    // Operands load on issue and hold otherwise, so the wrapper's input
    // register can sample them on any enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_p0 <= '0;
            op_b_p0 <= '0;
        end else if (issue) begin
            op_a_p0 <= sel_a;
            op_b_p0 <= sel_b;
        end
    end

    // ---- tag pipeline: one stage per edge of multiplier latency ----
    // Tag valid bits; these must clear on reset so no stale result retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else begin
            vld_p[0] <= issue;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Tag requester index; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        idx_p[0] <= grant_idx;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            idx_p[k] <= idx_p[k-1];
        end
    end

    // Next occupancy: issue and retire on the same edge cancel out.
    always_comb begin
        inflight_next = inflight;
        if (issue && !retire) begin
            inflight_next = inflight + CNT_W'(1);
        end else if (!issue && retire) begin
            inflight_next = inflight - CNT_W'(1);
        end
    end

    // Occupancy counter, bounded by the tag pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
        end
    end

    // ---- retire stage: return the product to its requester ----
    // One-cycle one-hot strobe; data holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld <= '0;
            res_dat <= '0;
        end else if (retire) begin
            res_vld <= onehot(idx_p[MUL_LATENCY-1]);
            res_dat <= bus.mul_result;
        end else begin
            res_vld <= '0;
        end
    end

    // Sequencer FSM; the enable follows the next state so the wrapper keeps
    // clocking until the last in-flight operation has retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ena   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= ACTIVE;
                        ena   <= 1'b1;
                    end else begin
                        ena   <= 1'b0;
                    end
                end
                ACTIVE, DRAIN: begin
                    if (issue) begin
                        state <= ACTIVE;
                        ena   <= 1'b1;
                    end else if (inflight_next != '0) begin
                        state <= DRAIN;
                        ena   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        ena   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ena   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.mul_ena   = ena;
    assign bus.mul_a     = op_a_p0;
    assign bus.mul_b     = op_b_p0;
    assign bus.res_valid = res_vld;
    assign bus.res_data  = res_dat;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed and randomized checks of fp_mul_arbiter against
// a scoreboard of expected products, driven through the interface. The
// multiplier wrapper is modelled here as MUL_LATENCY-1 enable-gated stages.
module tb_fp_mul_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 4;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] prod;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fp_mul_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

    fp_mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mptr     = 0;
    exp_t        q[$];
    logic [N-1:0] pend;
    logic [31:0] opa [N];
    logic [31:0] opb [N];
    logic [31:0] exp_res;
    logic [31:0] exp_mul_a;
    logic [31:0] exp_mul_b;
    logic [31:0] mpipe [L-1];

    // Exact single-precision product for normal operands whose mantissas
    // carry at most 8 significant fraction bits (no rounding needed).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(120, 134));
        r[22:15] = 8'($urandom_range(0, 255));
        r[14:0]  = '0;
        return r;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Reference grant rule: nothing under hold, else first valid from pointer.
    function automatic int model_grant(input logic [N-1:0] v, input logic h, input int p);
        int s;
        if (h) return -1;
        s = p;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        s = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    // Multiplier wrapper model: product appears L-1 enabled edges after capture.
    always_ff @(posedge clk) begin
        if (bus.mul_ena) begin
            mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
            for (int k = 1; k < L - 1; k++) begin
                mpipe[k] <= mpipe[k-1];
            end
        end
    end
    assign bus.mul_result = mpipe[L-2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] mask, input logic hold);
        logic [N*DW-1:0] pa;
        logic [N*DW-1:0] pb;
        pa = '0;
        pb = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pend[i]) begin
                opa[i] = rand_fp();
                opb[i] = rand_fp();
            end
            pend[i] = mask[i];
            pa = pa | ({{((N-1)*DW){1'b0}}, opa[i]} << (i * DW));
            pb = pb | ({{((N-1)*DW){1'b0}}, opb[i]} << (i * DW));
        end
        bus.req_a     = pa;
        bus.req_b     = pb;
        bus.req_valid = pend;
        bus.arb_hold  = hold;
    endtask

    // One clock cycle: drive, check grant, advance the model, check outputs.
    task automatic tick(input logic [N-1:0] mask, input logic hold, output logic [N-1:0] rdy);
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        drive(mask, hold);
        #2;
        g = model_grant(pend, hold, mptr);
        exp_rdy = (g >= 0) ? oh(g) : '0;
        rdy = bus.req_ready;
        check("req_ready", bus.req_ready, exp_rdy);
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            q.push_back('{due: cyc + L, idx: g, prod: fmul(opa[g], opb[g])});
            exp_mul_a = opa[g];
            exp_mul_b = opb[g];
            mptr = (g + 1) % N;
            pend[g] = 1'b0;
        end
        #1;
        exp_rv = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv  = oh(q[0].idx);
            exp_res = q[0].prod;
            void'(q.pop_front());
        end
        check("res_valid", bus.res_valid, exp_rv);
        check("res_data", bus.res_data, exp_res);
        check("mul_ena", bus.mul_ena, q.size() != 0);
        check("busy", bus.busy, q.size() != 0);
        check("mul_a", bus.mul_a, exp_mul_a);
        check("mul_b", bus.mul_b, exp_mul_b);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        pend          = '0;
        bus.req_valid = '0;
        bus.arb_hold  = 1'b0;
        q.delete();
        mptr      = 0;
        exp_res   = '0;
        exp_mul_a = '0;
        exp_mul_b = '0;
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_mul_ena", bus.mul_ena, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mul_a", bus.mul_a, 0);
        check("rst_mul_b", bus.mul_b, 0);
        check("rst_req_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rdy;
        logic [N-1:0] m;
        int           exp_i;
        pend          = '0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.arb_hold  = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        #3;
        do_reset();

        // Single request: 2.0 * 3.0 from requester 1.
        opa[1]  = 32'h4000_0000;
        opb[1]  = 32'h4040_0000;
        pend[1] = 1'b1;
        tick(4'b0010, 1'b0, rdy);
        check("single_grant", rdy, 4'b0010);
        repeat (L) tick(4'b0000, 1'b0, rdy);
        check("single_res_valid", bus.res_valid, 4'b0010);
        check("single_res_data", bus.res_data, 32'h40C0_0000);
        check("single_idle_ena", bus.mul_ena, 0);
        check("single_idle_busy", bus.busy, 0);
        repeat (2) tick(4'b0000, 1'b0, rdy);

        // All requesters valid for 8 cycles from a reset pointer.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(4'b1111, 1'b0, rdy);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            exp_i = 0;
`else
            exp_i = i % N;
`endif
            check("rr_order", rdy, oh(exp_i));
        end
        repeat (L + 1) tick(4'b0000, 1'b0, rdy);

        // Two in flight, then hold long enough for both to drain.
        tick(4'b0001, 1'b0, rdy);
        tick(4'b0010, 1'b0, rdy);
        for (int i = 0; i < L + 2; i++) begin
            tick(4'b1111, 1'b1, rdy);
            check("hold_nogrant", rdy, 0);
        end
        check("hold_drained", bus.busy, 0);
        tick(4'b1111, 1'b0, rdy);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        exp_i = 0;
`else
        exp_i = 2;
`endif
        check("hold_resume", rdy, oh(exp_i));

        // Reset two cycles after three issues discards the in-flight work.
        tick(4'b1111, 1'b0, rdy);
        tick(4'b1111, 1'b0, rdy);
        tick(4'b0000, 1'b0, rdy);
        tick(4'b0000, 1'b0, rdy);
        do_reset();
        repeat (L + 1) tick(4'b0000, 1'b0, rdy);
        for (int i = 0; i < 3; i++) begin
            tick(4'b1011, 1'b0, rdy);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            exp_i = 0;
`else
            exp_i = (i == 2) ? 3 : i;
`endif
            check("post_rst_grant", rdy, oh(exp_i));
        end
        repeat (L + 1) tick(4'b0000, 1'b0, rdy);

        // Randomized traffic with holds and withdrawn requests.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                m[i] = pend[i] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
            end
            tick(m, $urandom_range(0, 7) == 0, rdy);
        end
        repeat (L + 2) tick(4'b0000, 1'b0, rdy);
        check("final_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
